// File: rtl/axi4_lite_master_pkg.sv
// Response codes, fixed channel attributes and FSM encodings for the AXI4-Lite master.
package axi4_lite_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] FULL_STROBE  = 4'hF;
  localparam logic [2:0] DEFAULT_PROT = 3'b000;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } writeState_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } readState_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-beat AXI4-Lite master driven by a simple start-pulse command interface.
// Writes and reads run in two independent FSMs so both can be in flight at once.
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int AXI_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [AXI_ADDR_W-1:0] AMCI_WADDR,
  input  logic [31:0]           AMCI_WDATA,
  input  logic                  AMCI_WRITE,
  output logic [1:0]            AMCI_WRESP,
  output logic                  AMCI_WIDLE,

  input  logic [AXI_ADDR_W-1:0] AMCI_RADDR,
  input  logic                  AMCI_READ,
  output logic [31:0]           AMCI_RDATA,
  output logic [1:0]            AMCI_RRESP,
  output logic                  AMCI_RIDLE,

  output logic [AXI_ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,

  output logic [AXI_ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,

  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  writeState_t           r_wState;
  writeState_t           w_wStateNext;
  logic                  r_awDone;
  logic                  r_wDone;
  logic [AXI_ADDR_W-1:0] r_wAddr;
  logic [31:0]           r_wData;
  logic [1:0]            r_wResp;
  logic                  w_awValid;
  logic                  w_wValid;
  logic                  w_bReady;
  logic                  w_awHs;
  logic                  w_wHs;

  readState_t            r_rState;
  readState_t            w_rStateNext;
  logic [AXI_ADDR_W-1:0] r_rAddr;
  logic [31:0]           r_rData;
  logic [1:0]            r_rResp;
  logic                  w_arValid;
  logic                  w_rReady;

  assign w_awHs = w_awValid && M_AXI_AWREADY;
  assign w_wHs  = w_wValid && M_AXI_WREADY;

  // Write FSM state register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wState <= W_IDLE;
    else       r_wState <= w_wStateNext;
  end

  // Write next state: leave the address/data phase only when both beats have been accepted.
  always_comb begin
    w_wStateNext = r_wState;
    case (r_wState)
      W_IDLE:      if (AMCI_WRITE) w_wStateNext = W_ADDR_DATA;
      W_ADDR_DATA: if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) w_wStateNext = W_RESP;
      W_RESP:      if (M_AXI_BVALID) w_wStateNext = W_IDLE;
      default:     w_wStateNext = W_IDLE;
    endcase
  end

  // Write channel handshakes are decoded from state plus per-channel completion flags.
  always_comb begin
    w_awValid = (r_wState == W_ADDR_DATA) && !r_awDone;
    w_wValid  = (r_wState == W_ADDR_DATA) && !r_wDone;
    w_bReady  = (r_wState == W_RESP);
  end

  // Write datapath: capture the command, track which beats are done, latch the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awDone <= 1'b0;
      r_wDone  <= 1'b0;
      r_wAddr  <= '0;
      r_wData  <= '0;
      r_wResp  <= RESP_OKAY;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (AMCI_WRITE) begin
            r_wAddr  <= AMCI_WADDR;
            r_wData  <= AMCI_WDATA;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
          end
        end
        W_ADDR_DATA: begin
          if (w_awHs) r_awDone <= 1'b1;
          if (w_wHs)  r_wDone  <= 1'b1;
        end
        W_RESP: begin
          if (M_AXI_BVALID) r_wResp <= M_AXI_BRESP;
        end
        default: ;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rState <= R_IDLE;
    else       r_rState <= w_rStateNext;
  end

  // Read next state: address beat, then wait for the data beat.
  always_comb begin
    w_rStateNext = r_rState;
    case (r_rState)
      R_IDLE:  if (AMCI_READ) w_rStateNext = R_ADDR;
      R_ADDR:  if (M_AXI_ARREADY) w_rStateNext = R_DATA;
      R_DATA:  if (M_AXI_RVALID) w_rStateNext = R_IDLE;
      default: w_rStateNext = R_IDLE;
    endcase
  end

  // Read channel handshakes follow directly from the read state.
  always_comb begin
    w_arValid = (r_rState == R_ADDR);
    w_rReady  = (r_rState == R_DATA);
  end

  // Read datapath: capture the address and latch data and response on the R beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rAddr <= '0;
      r_rData <= '0;
      r_rResp <= RESP_OKAY;
    end else begin
      if ((r_rState == R_IDLE) && AMCI_READ) r_rAddr <= AMCI_RADDR;
      if ((r_rState == R_DATA) && M_AXI_RVALID) begin
        r_rData <= M_AXI_RDATA;
        r_rResp <= M_AXI_RRESP;
      end
    end
  end

  assign M_AXI_AWADDR  = r_wAddr;
  assign M_AXI_AWPROT  = DEFAULT_PROT;
  assign M_AXI_AWVALID = w_awValid;
  assign M_AXI_WDATA   = r_wData;
  assign M_AXI_WSTRB   = FULL_STROBE;
  assign M_AXI_WVALID  = w_wValid;
  assign M_AXI_BREADY  = w_bReady;
  assign M_AXI_ARADDR  = r_rAddr;
  assign M_AXI_ARPROT  = DEFAULT_PROT;
  assign M_AXI_ARVALID = w_arValid;
  assign M_AXI_RREADY  = w_rReady;

  assign AMCI_WRESP = r_wResp;
  assign AMCI_WIDLE = (r_wState == W_IDLE) && !AMCI_WRITE;
  assign AMCI_RDATA = r_rData;
  assign AMCI_RRESP = r_rResp;
  assign AMCI_RIDLE = (r_rState == R_IDLE) && !AMCI_READ;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a delay-configurable AXI4-Lite slave model plus
// directed and randomized command sequences checked against a memory-level reference.
module tb_axi4_lite_master;
  import axi4_lite_master_pkg::*;

  localparam int MAX_WAIT = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] AMCI_WADDR, AMCI_WDATA, AMCI_RADDR, AMCI_RDATA;
  logic        AMCI_WRITE, AMCI_READ, AMCI_WIDLE, AMCI_RIDLE;
  logic [1:0]  AMCI_WRESP, AMCI_RRESP;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int checks = 0;
  int errors = 0;

  // Slave knobs (written by tests) and slave bookkeeping (written only by the slave process).
  int awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
  int awCnt, wCnt, bCnt, arCnt, rCnt;
  bit awGot, wGot, arGot, awPend, wPend, arPend;
  logic [31:0] gotAwAddr, gotWData, gotArAddr, pendAwAddr, pendWData, pendArAddr;
  int awBeats = 0;
  int protoErrors = 0;
  logic [31:0] slaveMem [64];
  bit          slaveWritten [64];

  // Reference model: expected memory image and the last AMCI results.
  logic [31:0] refMem [64];
  bit          refWritten [64];
  logic [1:0]  expWresp = 2'b00, expRresp = 2'b00;
  logic [31:0] expRdata = 32'h0;

  always #5 clk = ~clk;

  axi4_lite_master #(.AXI_ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
    .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
    .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ), .AMCI_RDATA(AMCI_RDATA),
    .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Address map: low 256 bytes are memory, next 256 give SLVERR, everything else DECERR.
  function automatic logic [1:0] respFor(input logic [31:0] a);
    if (a < 32'h100) return RESP_OKAY;
    else if (a < 32'h200) return RESP_SLVERR;
    else return RESP_DECERR;
  endfunction

  // Data returned for never-written or error addresses.
  function automatic logic [31:0] fillPattern(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (respFor(a) != RESP_OKAY) return fillPattern(a);
    if (refWritten[a[7:2]]) return refMem[a[7:2]];
    return fillPattern(a);
  endfunction

  task automatic refWrite(input logic [31:0] a, input logic [31:0] d);
    if (respFor(a) == RESP_OKAY) begin
      refMem[a[7:2]] = d;
      refWritten[a[7:2]] = 1'b1;
    end
  endtask

  // Slave model: observe handshakes with pre-edge values, then drive new responses 1 ns later.
  always @(posedge clk) begin
    bit awHs, wHs, bHs, arHs, rHs;
    if (reset) begin
      awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
      awGot = 0; wGot = 0; arGot = 0; awPend = 0; wPend = 0; arPend = 0;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    end else begin
      awHs = M_AXI_AWVALID && M_AXI_AWREADY;
      wHs  = M_AXI_WVALID && M_AXI_WREADY;
      bHs  = M_AXI_BVALID && M_AXI_BREADY;
      arHs = M_AXI_ARVALID && M_AXI_ARREADY;
      rHs  = M_AXI_RVALID && M_AXI_RREADY;
      if (awPend && (!M_AXI_AWVALID || M_AXI_AWADDR !== pendAwAddr)) protoErrors++;
      if (wPend && (!M_AXI_WVALID || M_AXI_WDATA !== pendWData)) protoErrors++;
      if (arPend && (!M_AXI_ARVALID || M_AXI_ARADDR !== pendArAddr)) protoErrors++;
      if (M_AXI_BREADY && !(awGot && wGot)) protoErrors++;
      if (M_AXI_WSTRB !== 4'hF || M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) protoErrors++;
      awPend = M_AXI_AWVALID && !M_AXI_AWREADY; pendAwAddr = M_AXI_AWADDR;
      wPend  = M_AXI_WVALID && !M_AXI_WREADY;   pendWData  = M_AXI_WDATA;
      arPend = M_AXI_ARVALID && !M_AXI_ARREADY; pendArAddr = M_AXI_ARADDR;
      if (bHs) begin awGot = 0; wGot = 0; bCnt = 0; end
      if (rHs) begin arGot = 0; rCnt = 0; end
      if (awHs) begin awGot = 1; gotAwAddr = M_AXI_AWADDR; awBeats++; awCnt = 0; end
      if (wHs) begin wGot = 1; gotWData = M_AXI_WDATA; wCnt = 0; end
      if (arHs) begin arGot = 1; gotArAddr = M_AXI_ARADDR; arCnt = 0; end
      #1;
      if (bHs) M_AXI_BVALID = 0;
      if (rHs) M_AXI_RVALID = 0;
      M_AXI_AWREADY = M_AXI_AWVALID && (awCnt >= awDelay);
      if (M_AXI_AWVALID && !M_AXI_AWREADY) awCnt++;
      M_AXI_WREADY = M_AXI_WVALID && (wCnt >= wDelay);
      if (M_AXI_WVALID && !M_AXI_WREADY) wCnt++;
      M_AXI_ARREADY = M_AXI_ARVALID && (arCnt >= arDelay);
      if (M_AXI_ARVALID && !M_AXI_ARREADY) arCnt++;
      if (awGot && wGot && !M_AXI_BVALID) begin
        if (bCnt >= bDelay) begin
          M_AXI_BVALID = 1;
          M_AXI_BRESP = respFor(gotAwAddr);
          if (M_AXI_BRESP == RESP_OKAY) begin
            slaveMem[gotAwAddr[7:2]] = gotWData;
            slaveWritten[gotAwAddr[7:2]] = 1'b1;
          end
        end else bCnt++;
      end
      if (arGot && !M_AXI_RVALID) begin
        if (rCnt >= rDelay) begin
          M_AXI_RVALID = 1;
          M_AXI_RRESP = respFor(gotArAddr);
          if (M_AXI_RRESP == RESP_OKAY && slaveWritten[gotArAddr[7:2]])
            M_AXI_RDATA = slaveMem[gotArAddr[7:2]];
          else
            M_AXI_RDATA = fillPattern(gotArAddr);
        end else rCnt++;
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setDelays(input int aw, input int w, input int b, input int ar, input int r);
    awDelay = aw; wDelay = w; bDelay = b; arDelay = ar; rDelay = r;
  endtask

  task automatic applyWriteStimulus(input logic [31:0] a, input logic [31:0] d);
    AMCI_WADDR = a; AMCI_WDATA = d; AMCI_WRITE = 1'b1;
    @(negedge clk);
    AMCI_WRITE = 1'b0;
  endtask

  task automatic applyReadStimulus(input logic [31:0] a);
    AMCI_RADDR = a; AMCI_READ = 1'b1;
    @(negedge clk);
    AMCI_READ = 1'b0;
  endtask

  task automatic waitIdle(input bit isWrite, output int cycles, output bit timedOut);
    cycles = 0;
    while (((isWrite && !AMCI_WIDLE) || (!isWrite && !AMCI_RIDLE)) && cycles < MAX_WAIT) begin
      @(negedge clk);
      cycles++;
    end
    timedOut = isWrite ? !AMCI_WIDLE : !AMCI_RIDLE;
  endtask

  task automatic test_reset();
    AMCI_WRITE = 0; AMCI_READ = 0; AMCI_WADDR = 0; AMCI_WDATA = 0; AMCI_RADDR = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshakes: got %b required 00000",
               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    checks++;
    if ({AMCI_WRESP, AMCI_RRESP} !== 4'b0 || AMCI_RDATA !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_results: wresp %0d rresp %0d rdata %h required 0 0 0",
               AMCI_WRESP, AMCI_RRESP, AMCI_RDATA);
    end
    checks++;
    if ({AMCI_WIDLE, AMCI_RIDLE} !== 2'b11 || M_AXI_WSTRB !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reset_idle: idle %b wstrb %h required 11 f",
               {AMCI_WIDLE, AMCI_RIDLE}, M_AXI_WSTRB);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    int cycles, startBeats;
    bit to;
    setDelays(0, 0, 0, 0, 0);
    startBeats = awBeats;
    AMCI_WADDR = 32'h0000_0004; AMCI_WDATA = 32'h1234_5678; AMCI_WRITE = 1'b1;
    #1;
    checks++;
    if (AMCI_WIDLE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL widle_with_start: got %b required 0", AMCI_WIDLE);
    end
    @(negedge clk);
    AMCI_WRITE = 1'b0;
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWREADY, M_AXI_WREADY} !== 4'hF ||
        M_AXI_AWADDR !== 32'h4 || M_AXI_WDATA !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL basic_aw_w_same_cycle: vr %b addr %h data %h required 1111 4 12345678",
               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWREADY, M_AXI_WREADY}, M_AXI_AWADDR, M_AXI_WDATA);
    end
    waitIdle(1'b1, cycles, to);
    refWrite(32'h4, 32'h1234_5678);
    expWresp = RESP_OKAY;
    checks++;
    if (to || cycles + 1 !== 3) begin
      errors++;
      $display("[TB] FAIL basic_write_latency: got %0d cycles (timeout %0d) required 3", cycles + 1, to);
    end
    checks++;
    if (AMCI_WRESP !== expWresp || awBeats - startBeats !== 1) begin
      errors++;
      $display("[TB] FAIL basic_write_resp: wresp %0d beats %0d required %0d 1",
               AMCI_WRESP, awBeats - startBeats, expWresp);
    end
  endtask

  task automatic test_delayed_aw();
    int n, awHigh, addrBad, bEarly;
    bit wFirst;
    logic [31:0] d;
    setDelays(5, 0, 0, 0, 0);
    d = $urandom;
    applyWriteStimulus(32'h10, d);
    n = 0; awHigh = 0; addrBad = 0; bEarly = 0; wFirst = 0;
    while (!AMCI_WIDLE && n < MAX_WAIT) begin
      if (M_AXI_AWVALID) begin
        awHigh++;
        if (M_AXI_AWADDR !== 32'h10) addrBad++;
        if (M_AXI_BREADY) bEarly++;
        if (!M_AXI_WVALID) wFirst = 1;
      end
      @(negedge clk);
      n++;
    end
    refWrite(32'h10, d);
    checks++;
    if (!AMCI_WIDLE) begin
      errors++;
      $display("[TB] FAIL delayed_aw_timeout: still busy after %0d cycles", n);
    end
    checks++;
    if (!wFirst || awHigh !== 6) begin
      errors++;
      $display("[TB] FAIL delayed_aw_order: wFirst %0d awvalid cycles %0d required 1 6", wFirst, awHigh);
    end
    checks++;
    if (addrBad !== 0 || bEarly !== 0) begin
      errors++;
      $display("[TB] FAIL delayed_aw_stability: addr changes %0d early bready %0d required 0 0",
               addrBad, bEarly);
    end
    checks++;
    if (AMCI_WRESP !== expWresp) begin
      errors++;
      $display("[TB] FAIL delayed_aw_resp: got %0d required %0d", AMCI_WRESP, expWresp);
    end
  endtask

  task automatic test_read();
    int cycles;
    bit to;
    setDelays(0, 0, 0, 0, 0);
    applyWriteStimulus(32'h8, 32'h0000_0007);
    waitIdle(1'b1, cycles, to);
    refWrite(32'h8, 32'h0000_0007);
    setDelays(0, 0, 0, 0, 3);
    applyReadStimulus(32'h8);
    waitIdle(1'b0, cycles, to);
    expRdata = refRead(32'h8);
    expRresp = respFor(32'h8);
    checks++;
    if (to || cycles !== 2 + 3) begin
      errors++;
      $display("[TB] FAIL read_latency: got %0d (timeout %0d) required 5", cycles, to);
    end
    checks++;
    if (AMCI_RDATA !== expRdata || AMCI_RRESP !== expRresp) begin
      errors++;
      $display("[TB] FAIL read_data: rdata %h rresp %0d required %h %0d",
               AMCI_RDATA, AMCI_RRESP, expRdata, expRresp);
    end
    checks++;
    if (AMCI_WRESP !== expWresp) begin
      errors++;
      $display("[TB] FAIL wresp_hold: got %0d required %0d", AMCI_WRESP, expWresp);
    end
  endtask

  task automatic test_error_resp();
    int cycles;
    bit to;
    logic [31:0] a;
    setDelays(0, 0, 0, 0, 0);
    a = 32'h4000_0000;
    applyReadStimulus(a);
    waitIdle(1'b0, cycles, to);
    expRresp = respFor(a);
    expRdata = refRead(a);
    checks++;
    if (to || AMCI_RRESP !== 2'd3 || AMCI_RDATA !== expRdata) begin
      errors++;
      $display("[TB] FAIL decerr_read: rresp %0d rdata %h required 3 %h", AMCI_RRESP, AMCI_RDATA, expRdata);
    end
    applyWriteStimulus(32'h140, 32'hCAFE_F00D);
    waitIdle(1'b1, cycles, to);
    expWresp = respFor(32'h140);
    checks++;
    if (to || AMCI_WRESP !== 2'd2) begin
      errors++;
      $display("[TB] FAIL slverr_write: wresp %0d required 2", AMCI_WRESP);
    end
  endtask

  task automatic test_back_to_back();
    int n, startBeats;
    logic [31:0] d1, d2;
    setDelays(2, 0, 0, 0, 1);
    d1 = $urandom; d2 = $urandom;
    startBeats = awBeats;
    AMCI_WADDR = 32'h20; AMCI_WDATA = d1; AMCI_WRITE = 1'b1;
    AMCI_RADDR = 32'h24; AMCI_READ = 1'b1;
    @(negedge clk);
    AMCI_WRITE = 1'b0; AMCI_READ = 1'b0;
    @(negedge clk);
    AMCI_WADDR = 32'h30; AMCI_WDATA = d2; AMCI_WRITE = 1'b1;
    @(negedge clk);
    AMCI_WRITE = 1'b0;
    n = 0;
    while (!(AMCI_WIDLE && AMCI_RIDLE) && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    refWrite(32'h20, d1);
    expWresp = respFor(32'h20);
    expRresp = respFor(32'h24);
    expRdata = refRead(32'h24);
    checks++;
    if (!(AMCI_WIDLE && AMCI_RIDLE)) begin
      errors++;
      $display("[TB] FAIL concurrent_timeout: idle w %b r %b after %0d cycles", AMCI_WIDLE, AMCI_RIDLE, n);
    end
    checks++;
    if (awBeats - startBeats !== 1 || gotAwAddr !== 32'h20) begin
      errors++;
      $display("[TB] FAIL busy_write_ignored: beats %0d last addr %h required 1 00000020",
               awBeats - startBeats, gotAwAddr);
    end
    checks++;
    if (AMCI_WRESP !== expWresp || AMCI_RRESP !== expRresp || AMCI_RDATA !== expRdata) begin
      errors++;
      $display("[TB] FAIL concurrent_results: wresp %0d rresp %0d rdata %h required %0d %0d %h",
               AMCI_WRESP, AMCI_RRESP, AMCI_RDATA, expWresp, expRresp, expRdata);
    end
    setDelays(0, 0, 0, 0, 0);
    applyReadStimulus(32'h30);
    while (!AMCI_RIDLE && n < 2 * MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    expRdata = refRead(32'h30);
    expRresp = respFor(32'h30);
    checks++;
    if (AMCI_RDATA !== expRdata) begin
      errors++;
      $display("[TB] FAIL ignored_write_not_stored: rdata %h required %h", AMCI_RDATA, expRdata);
    end
  endtask

  task automatic test_reset_in_resp();
    int n, cycles;
    bit to;
    logic [31:0] d;
    setDelays(0, 0, 4, 0, 0);
    d = $urandom;
    applyWriteStimulus(32'h40, d);
    n = 0;
    while (!M_AXI_BREADY && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!M_AXI_BREADY || AMCI_WRESP !== expWresp) begin
      errors++;
      $display("[TB] FAIL reach_wresp_state: bready %b wresp %0d required 1 %0d", M_AXI_BREADY, AMCI_WRESP, expWresp);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (M_AXI_BREADY !== 1'b0 || AMCI_WRESP !== 2'b00 || AMCI_RDATA !== 32'h0 || AMCI_WIDLE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_resp: bready %b wresp %0d rdata %h widle %b required 0 0 0 1",
               M_AXI_BREADY, AMCI_WRESP, AMCI_RDATA, AMCI_WIDLE);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expWresp = 2'b00; expRresp = 2'b00; expRdata = 32'h0;
    @(negedge clk);
    setDelays(0, 0, 0, 0, 0);
    d = $urandom;
    applyWriteStimulus(32'h44, d);
    waitIdle(1'b1, cycles, to);
    refWrite(32'h44, d);
    expWresp = respFor(32'h44);
    checks++;
    if (to || cycles + 1 !== 3 || AMCI_WRESP !== expWresp) begin
      errors++;
      $display("[TB] FAIL write_after_reset: latency %0d wresp %0d required 3 %0d", cycles + 1, AMCI_WRESP, expWresp);
    end
    applyReadStimulus(32'h40);
    waitIdle(1'b0, cycles, to);
    expRdata = refRead(32'h40);
    expRresp = respFor(32'h40);
    checks++;
    if (to || AMCI_RDATA !== expRdata) begin
      errors++;
      $display("[TB] FAIL abandoned_write_absent: rdata %h required %h", AMCI_RDATA, expRdata);
    end
  endtask

  task automatic test_random();
    int cycles, sel;
    bit to, isWrite;
    logic [31:0] a, d;
    for (int i = 0; i < 40; i++) begin
      setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel < 9) a = 32'h100 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else              a = {8'($urandom_range(1, 255)), 24'h0};
      d = $urandom;
      isWrite = $urandom_range(0, 1) == 1;
      if (isWrite) begin
        applyWriteStimulus(a, d);
        refWrite(a, d);
        expWresp = respFor(a);
      end else begin
        applyReadStimulus(a);
        expRresp = respFor(a);
        expRdata = refRead(a);
      end
      waitIdle(isWrite, cycles, to);
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL random_timeout op %0d: busy after %0d cycles", i, cycles);
      end
      checks++;
      if (AMCI_WRESP !== expWresp) begin
        errors++;
        $display("[TB] FAIL random_wresp op %0d addr %h: got %0d required %0d", i, a, AMCI_WRESP, expWresp);
      end
      checks++;
      if (AMCI_RRESP !== expRresp || AMCI_RDATA !== expRdata) begin
        errors++;
        $display("[TB] FAIL random_read op %0d addr %h: rresp %0d rdata %h required %0d %h",
                 i, a, AMCI_RRESP, AMCI_RDATA, expRresp, expRdata);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (protoErrors !== 0) begin
      errors++;
      $display("[TB] FAIL protocol_rules: got %0d violations required 0", protoErrors);
    end
  endtask

  // Scenario sequence; each task does its own comparisons.
  initial begin
    test_reset();
    test_basic_write();
    test_delayed_aw();
    test_read();
    test_error_resp();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have one parameter: AXI_ADDR_W, default 32, AXI address width.
REQ-002 SHALL have port clk, in, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port reset, in, 1: reset is asynchronous and active-high.
REQ-004 SHALL have AMCI write ports AMCI_WADDR (in, AXI_ADDR_W), AMCI_WDATA (in, 32), AMCI_WRITE (in, 1, start pulse), AMCI_WRESP (out, 2), AMCI_WIDLE (out, 1).
REQ-005 SHALL have AMCI read ports AMCI_RADDR (in, AXI_ADDR_W), AMCI_READ (in, 1, start pulse), AMCI_RDATA (out, 32), AMCI_RRESP (out, 2), AMCI_RIDLE (out, 1).
REQ-006 SHALL have the AW channel: M_AXI_AWADDR out AXI_ADDR_W, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-007 SHALL have the W channel: M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-008 SHALL have the B channel: M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-009 SHALL have the AR channel: M_AXI_ARADDR out AXI_ADDR_W, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-010 SHALL have the R channel: M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-011 SHALL run independent write and read FSMs; a read and a write may be in flight concurrently.
REQ-012 Write FSM states SHALL be W_IDLE, W_ADDR_DATA and W_RESP.
REQ-013 W_IDLE with AMCI_WRITE=1 SHALL capture the address and data, assert AWVALID and WVALID on the next cycle, and go to W_ADDR_DATA.
REQ-014 In W_ADDR_DATA, AWVALID SHALL drop the cycle after AWVALID&&AWREADY, and WVALID SHALL drop the cycle after WVALID&&WREADY; the two handshakes are independent and may complete in either order or in the same cycle.
REQ-015 Once both handshakes are complete, the write FSM SHALL assert BREADY and enter W_RESP.
REQ-016 In W_RESP, BVALID&&BREADY SHALL register BRESP into AMCI_WRESP, deassert BREADY and return to W_IDLE; write latency is 3 cycles minimum with zero-wait slave.
REQ-017 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA.
REQ-018 R_IDLE with AMCI_READ=1 SHALL capture the address, assert ARVALID and go to R_ADDR.
REQ-019 ARVALID&&ARREADY SHALL deassert ARVALID, assert RREADY and enter R_DATA.
REQ-020 RVALID&&RREADY SHALL register RDATA into AMCI_RDATA and RRESP into AMCI_RRESP, deassert RREADY and return to R_IDLE.
REQ-021 AMCI_WIDLE SHALL equal (write state==W_IDLE)&&!AMCI_WRITE, and AMCI_RIDLE SHALL equal the read equivalent.
REQ-022 AMCI_WRITE or AMCI_READ asserted while its FSM is not idle SHALL be ignored, with no capture and no queueing.
REQ-023 Once asserted, a VALID SHALL hold, with stable address and data, until its handshake completes.
REQ-024 WSTRB SHALL be 4'hF and AWPROT/ARPROT SHALL be 3'b000 constantly.
REQ-025 AMCI_WRESP, AMCI_RRESP and AMCI_RDATA SHALL hold their last value until the next completed transaction.
REQ-026 Response codes SHALL be passed through unmodified: OKAY=0, SLVERR=2, DECERR=3.

Reset
REQ-027 Asserting reset SHALL immediately clear all VALID/READY outputs to 0, both FSMs to IDLE, AMCI_WRESP/AMCI_RRESP to 0 and AMCI_RDATA to 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction, with no AMCI response update.
REQ-029 After reset deasserts, the first start pulse SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the response-code constants (OKAY/EXOKAY/SLVERR/DECERR) and the FSM state encodings.
REQ-031 The block SHALL have no sub-module; the two FSMs are inline.

Verification
REQ-032 Write 0x0000_0004 <- 0x1234_5678 with an always-ready slave SHALL produce AW/W handshakes on the same cycle and AMCI_WRESP=0; AMCI_WIDLE SHALL return high 3 cycles after the start pulse.
REQ-033 Write with AWREADY delayed 5 cycles and WREADY immediate SHALL drop WVALID first, hold AWVALID with a stable address, and leave BREADY low until both handshakes complete.
REQ-034 Read 0x8 with slave RDATA=0x0000_0007 and RRESP=0 after a 3-cycle RVALID delay SHALL give AMCI_RDATA=0x0000_0007 and AMCI_RRESP=0.
REQ-035 Read of an unmapped address returning DECERR SHALL give AMCI_RRESP=3, with AMCI_RDATA updated to the slave's RDATA.
REQ-036 Concurrent write and read starts on the same cycle SHALL both complete, and a second AMCI_WRITE issued while busy SHALL be ignored, with exactly one AW beat observed.
REQ-037 Reset asserted while in W_RESP SHALL drop BREADY the same cycle, leave AMCI_WRESP=0, and a subsequent write SHALL complete normally.
